// File: rtl/ps2_pkg.sv
// Shared types and defaults for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam int FRAME_BITS      = 11;
  localparam int DATA_BITS       = FRAME_BITS - 3;  // start, parity and stop bits excluded
  localparam int DEF_FILT_LEN    = 8;
  localparam int DEF_TIMEOUT_CYC = 200000;
  localparam int DEF_FIFO_AW     = 4;

  // PS/2 uses odd parity, so data plus parity must carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
    return ^{dat, par};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// First-word fall-through byte FIFO; a write is visible on rd_dat one cycle later.
// A write while full is accepted only if a read happens in the same cycle; reads while empty are ignored.
module ps2_byte_fifo #(
  parameter int AW = 4
) (
  input  logic          CLK100,
  input  logic          RST,
  input  logic          wr_vld,
  input  logic [7:0]    wr_dat,
  input  logic          rd_rdy,
  output logic [7:0]    rd_dat,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_ok;
  logic          rd_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  // Gate the head with empty so the port reads 0 instead of stale storage.
  assign rd_dat = empty ? 8'h00 : mem_q[rd_ptr_q];

  assign rd_ok = rd_rdy & ~empty;
  assign wr_ok = wr_vld & (~full | rd_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    if (wr_ok) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK100) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge CLK100) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync + run-length filter, 11-bit deframer, sticky errors, byte FIFO.
// A good byte reaches RD_DATA one cycle after its stop-bit strobe; a full FIFO drops it unless popped that cycle.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = DEF_FILT_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int FIFO_AW     = DEF_FIFO_AW
) (
  input  logic               CLK100,
  input  logic               RST,
  input  logic               PS2CLK_IN,
  input  logic               PS2DATA_IN,
  input  logic               RD_EN,
  input  logic               ERR_CLR,
  output logic [7:0]         RD_DATA,
  output logic               EMPTY,
  output logic               FULL,
  output logic [FIFO_AW:0]   COUNT,
  output logic               OVERRUN,
  output logic               PAR_ERR,
  output logic               FRM_ERR
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

  // Bit 0 carries the clock line, bit 1 the data line.
  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
  logic [FW-1:0] fcnt_q [2];
  logic [FW-1:0] fcnt_d [2];
  logic          fclk_dly_q, fclk_dly_d;
  logic          strobe, fdat;

  rx_state_e     state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ovr_q, ovr_d, perr_q, perr_d, ferr_q, ferr_d;

  logic          timeout, push_vld, frm_evt, par_evt, ovr_evt;
  logic          fifo_empty, fifo_full;

  always_comb begin
    sync1_d    = {PS2DATA_IN, PS2CLK_IN};
    sync2_d    = sync1_q;
    filt_d     = filt_q;
    fcnt_d     = fcnt_q;
    fclk_dly_d = filt_q[0];
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FW'(FILT_LEN - 1)) begin
          filt_d[i] = sync2_q[i];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end else begin
        fcnt_d[i] = '0;
      end
    end
  end

  assign strobe  = fclk_dly_q & ~filt_q[0];
  assign fdat    = filt_q[1];
  assign timeout = (state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK100) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = ST_IDLE;
    end else if (strobe) begin
      case (state_q)
        ST_IDLE:   if (!fdat) state_d = ST_DATA;
        ST_DATA:   if (bitcnt_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    push_vld = 1'b0;
    frm_evt  = timeout;
    par_evt  = 1'b0;
    if (strobe && !timeout && state_q == ST_STOP) begin
      if (!fdat)                             frm_evt  = 1'b1;
      else if (!odd_parity_ok(shift_q, par_q)) par_evt  = 1'b1;
      else                                   push_vld = 1'b1;
    end
  end

  // FULL implies non-empty, so a pop in the push cycle always frees a slot.
  assign ovr_evt = push_vld & fifo_full & ~RD_EN;

  always_comb begin
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tmo_d    = (state_q == ST_IDLE || strobe || timeout) ? '0 : tmo_q + 1'b1;
    if (strobe && !timeout) begin
      case (state_q)
        ST_IDLE:   bitcnt_d = '0;
        ST_DATA: begin
          shift_d  = {fdat, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
        end
        ST_PARITY: par_d = fdat;
        default:   ;
      endcase
    end
    ovr_d  = ovr_evt | (ovr_q & ~ERR_CLR);
    perr_d = par_evt | (perr_q & ~ERR_CLR);
    ferr_d = frm_evt | (ferr_q & ~ERR_CLR);
  end

  always_ff @(posedge CLK100) begin
    if (RST) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q     <= '{default: '0};
      fclk_dly_q <= 1'b1;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      ovr_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      fclk_dly_q <= fclk_dly_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      ovr_q      <= ovr_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  ps2_byte_fifo #(.AW(FIFO_AW)) u_fifo (
    .CLK100 (CLK100),
    .RST    (RST),
    .wr_vld (push_vld),
    .wr_dat (shift_q),
    .rd_rdy (RD_EN),
    .rd_dat (RD_DATA),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (COUNT)
  );

  assign EMPTY   = fifo_empty;
  assign FULL    = fifo_full;
  assign OVERRUN = ovr_q;
  assign PAR_ERR = perr_q;
  assign FRM_ERR = ferr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo with a shortened PS/2 bit period and timeout.
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int H   = 25;   // half PS/2 clock period in CLK100 cycles
  localparam int TMO = 400;

  logic       CLK100 = 1'b0;
  logic       RST, PS2CLK_IN, PS2DATA_IN, RD_EN, ERR_CLR;
  logic [7:0] RD_DATA;
  logic       EMPTY, FULL, OVERRUN, PAR_ERR, FRM_ERR;
  logic [4:0] COUNT;

  int tests  = 0;
  int failed = 0;

  always #5 CLK100 = ~CLK100;

  ps2_rx_fifo #(.FILT_LEN(8), .TIMEOUT_CYC(TMO), .FIFO_AW(4)) dut (
    .CLK100     (CLK100),
    .RST        (RST),
    .PS2CLK_IN  (PS2CLK_IN),
    .PS2DATA_IN (PS2DATA_IN),
    .RD_EN      (RD_EN),
    .ERR_CLR    (ERR_CLR),
    .RD_DATA    (RD_DATA),
    .EMPTY      (EMPTY),
    .FULL       (FULL),
    .COUNT      (COUNT),
    .OVERRUN    (OVERRUN),
    .PAR_ERR    (PAR_ERR),
    .FRM_ERR    (FRM_ERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK100);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_on_push);
    bit got = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      PS2DATA_IN = bits[i];
      wait_cyc(H);
      PS2CLK_IN = 1'b0;
      for (int c = 0; c < H; c++) begin
        @(negedge CLK100);
        RD_EN = 1'b0;
        if (pop_on_push && !got && dut.push_vld) begin
          RD_EN = 1'b1;
          got   = 1'b1;
        end
      end
      PS2CLK_IN = 1'b1;
    end
    @(negedge CLK100);
    RD_EN      = 1'b0;
    PS2DATA_IN = 1'b1;
    wait_cyc(H);
    if (pop_on_push) check("push_cycle_seen", 32'(got), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, input bit pop);
    send_bits({stp, par, b, 1'b0}, 11, pop);
  endtask

  task automatic send_good(input logic [7:0] b, input bit pop);
    send_frame(b, ~^b, 1'b1, pop);
  endtask

  task automatic pop_one();
    @(negedge CLK100);
    RD_EN = 1'b1;
    @(negedge CLK100);
    RD_EN = 1'b0;
  endtask

  task automatic clr_err();
    @(negedge CLK100);
    ERR_CLR = 1'b1;
    @(negedge CLK100);
    ERR_CLR = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"},   32'(EMPTY),   32'd1);
    check({tag, "_full"},    32'(FULL),    32'd0);
    check({tag, "_count"},   32'(COUNT),   32'd0);
    check({tag, "_rd_data"}, 32'(RD_DATA), 32'd0);
    check({tag, "_ovr"},     32'(OVERRUN), 32'd0);
    check({tag, "_perr"},    32'(PAR_ERR), 32'd0);
    check({tag, "_ferr"},    32'(FRM_ERR), 32'd0);
  endtask

  initial begin
    RST = 1'b1; PS2CLK_IN = 1'b1; PS2DATA_IN = 1'b1; RD_EN = 1'b0; ERR_CLR = 1'b0;
    wait_cyc(3);
    check_reset_outputs("reset");
    RST = 1'b0;
    wait_cyc(20);

    // Good frame 0x1C (three ones, parity 0), then pop and an ignored pop on empty.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_cyc(5);
    check("f1c_data",  32'(RD_DATA), 32'h1C);
    check("f1c_empty", 32'(EMPTY),   32'd0);
    check("f1c_count", 32'(COUNT),   32'd1);
    pop_one();
    check("pop_empty", 32'(EMPTY), 32'd1);
    check("pop_count", 32'(COUNT), 32'd0);
    pop_one();
    check("underflow_count", 32'(COUNT), 32'd0);
    check("underflow_empty", 32'(EMPTY), 32'd1);

    // 0xF0 has four ones, so parity 0 is wrong.
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    wait_cyc(5);
    check("perr_set",   32'(PAR_ERR), 32'd1);
    check("perr_empty", 32'(EMPTY),   32'd1);
    check("perr_ferr",  32'(FRM_ERR), 32'd0);
    clr_err();
    check("perr_clr", 32'(PAR_ERR), 32'd0);

    // 17 frames into a 16-deep FIFO: the last one is dropped.
    for (int b = 0; b < 17; b++) send_good(8'(b), 1'b0);
    wait_cyc(5);
    check("fill_full",  32'(FULL),    32'd1);
    check("fill_count", 32'(COUNT),   32'd16);
    check("fill_ovr",   32'(OVERRUN), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), 32'(RD_DATA), 32'(i));
      pop_one();
    end
    check("drain_empty", 32'(EMPTY), 32'd1);
    check("drain_count", 32'(COUNT), 32'd0);
    clr_err();
    check("ovr_clr", 32'(OVERRUN), 32'd0);

    // Start bit plus four data bits, then silence longer than the timeout.
    send_bits(11'b000_0000_1010, 5, 1'b0);
    wait_cyc(2 * TMO);
    check("tmo_ferr",  32'(FRM_ERR),     32'd1);
    check("tmo_idle",  32'(dut.state_q), 32'(ST_IDLE));
    check("tmo_empty", 32'(EMPTY),       32'd1);
    clr_err();
    send_good(8'h29, 1'b0);
    wait_cyc(5);
    check("f29_data",  32'(RD_DATA), 32'h29);
    check("f29_count", 32'(COUNT),   32'd1);
    check("f29_ferr",  32'(FRM_ERR), 32'd0);
    pop_one();

    // Short low glitches on the clock line are filtered out.
    repeat (4) begin
      PS2CLK_IN = 1'b0; wait_cyc(5);
      PS2CLK_IN = 1'b1; wait_cyc(20);
    end
    wait_cyc(30);
    check("glitch_empty", 32'(EMPTY),       32'd1);
    check("glitch_idle",  32'(dut.state_q), 32'(ST_IDLE));
    check("glitch_perr",  32'(PAR_ERR),     32'd0);
    check("glitch_ferr",  32'(FRM_ERR),     32'd0);
    check("glitch_ovr",   32'(OVERRUN),     32'd0);

    // Reset with a byte queued and a partial frame in flight.
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_good(8'h77, 1'b0);
    send_bits(11'b000_0001_0110, 5, 1'b0);
    @(negedge CLK100);
    RST = 1'b1;
    wait_cyc(2);
    RST = 1'b0;
    @(negedge CLK100);
    check_reset_outputs("midrst");
    check("midrst_idle", 32'(dut.state_q), 32'(ST_IDLE));
    send_good(8'h5A, 1'b0);
    wait_cyc(5);
    check("f5a_data",  32'(RD_DATA), 32'h5A);
    check("f5a_count", 32'(COUNT),   32'd1);
    pop_one();

    // Push into a full FIFO while popping: accepted, no overrun, newest read last.
    for (int b = 0; b < 16; b++) send_good(8'(8'h30 + b), 1'b0);
    wait_cyc(5);
    check("pp_full_before", 32'(FULL), 32'd1);
    send_good(8'h40, 1'b1);
    wait_cyc(5);
    check("pp_count", 32'(COUNT),   32'd16);
    check("pp_ovr",   32'(OVERRUN), 32'd0);
    check("pp_full",  32'(FULL),    32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("pp_drain_%0d", i), 32'(RD_DATA), 32'(8'h31 + i));
      pop_one();
    end
    check("pp_empty", 32'(EMPTY), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
